// File: rtl/ssd_pkg.sv
// ssd_pkg
// Shared constants for the seven-segment scan driver: all-off levels for the
// active-low anode and cathode buses, the digit count, and the hex-to-segment
// table in active-low {g,f,e,d,c,b,a} order.
package ssd_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;
    localparam logic [3:0]  ANODE_OFF  = 4'hF;

    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/ssd_scan_driver_hex_to_ssd.sv
// hex_to_ssd
// Combinational nibble to seven-segment decoder, active-low outputs.
// Ports:
//   nibble  in  4  hex digit to show
//   seg     out 7  segments {g,f,e,d,c,b,a}, 0 = lit
module hex_to_ssd
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
// Drives a 4-digit common-anode seven-segment display from an external 2-bit
// digit index. The index is double-flopped, every index change blanks the
// display for BLANK_CYCLES+1 cycles, and the displayed value is latched only
// on the 3->0 wrap so a scan never mixes two values.
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high
//   digit_sel  in   2   digit index (may be asynchronous to clk)
//   value_in   in  16   value to show, digit i = value_in[4i+3:4i]
//   dp_in      in   4   decimal point per digit, active-high
//   blank_lz   in   1   1 = suppress leading zeros
//   anode      out  4   digit enables, active-low
//   cathode    out  7   segments {g..a}, active-low
//   dp         out  1   decimal point, active-low
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  digit_sel,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp
);

    localparam int unsigned CNT_W = (BLANK_CYCLES == 0) ? 1 : $clog2(BLANK_CYCLES + 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

    logic [1:0]       sel_s1, sel_s2, sel_q;
    logic [15:0]      frame_value;
    logic [3:0]       frame_dp;
    logic             frame_lz;
    logic [CNT_W-1:0] blank_cnt;

    logic             ev;
    logic             wrap;
    logic [3:0]       nibble;
    logic [6:0]       seg;
    logic [3:0]       lz_sup;
    logic             lz_run;
    logic [3:0]       anode_nxt;
    logic [6:0]       cathode_nxt;
    logic             dp_nxt;

    assign ev     = (sel_s2 != sel_q);
    assign wrap   = ev && (sel_q == 2'd3) && (sel_s2 == 2'd0);
    assign nibble = frame_value[{sel_q, 2'b00} +: 4];

    hex_to_ssd u_hex (
        .nibble (nibble),
        .seg    (seg)
    );

    // A digit is suppressed when it and every more significant digit are
    // zero; digit 0 is excluded so a zero value still shows "0".
    always_comb begin
        lz_sup = '0;
        lz_run = frame_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run    = lz_run && (frame_value[4*i +: 4] == 4'h0);
            lz_sup[i] = lz_run;
        end
    end

    always_comb begin
        anode_nxt   = ANODE_OFF;
        cathode_nxt = SEG_OFF;
        dp_nxt      = 1'b1;
        if (!ev && (blank_cnt == '0) && !lz_sup[sel_q]) begin
            anode_nxt   = ~(4'b0001 << sel_q);
            cathode_nxt = seg;
            dp_nxt      = ~frame_dp[sel_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_s1      <= 2'd0;
            sel_s2      <= 2'd0;
            sel_q       <= 2'd0;
            frame_value <= 16'h0000;
            frame_dp    <= 4'h0;
            frame_lz    <= 1'b0;
            blank_cnt   <= '0;
            anode       <= ANODE_OFF;
            cathode     <= SEG_OFF;
            dp          <= 1'b1;
        end else begin
            sel_s1 <= digit_sel;
            sel_s2 <= sel_s1;
            sel_q  <= sel_s2;

            if (wrap) begin
                frame_value <= value_in;
                frame_dp    <= dp_in;
                frame_lz    <= blank_lz;
            end

            // Reload on every change so a second change inside a blank
            // window restarts the full all-off period.
            if (ev) begin
                blank_cnt <= BLANK_LOAD;
            end else if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - 1'b1;
            end

            anode   <= anode_nxt;
            cathode <= cathode_nxt;
            dp      <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;

    logic        clk;
    logic        reset;
    logic [1:0]  digit_sel;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp;

    int n_checks;
    int n_fail;

    ssd_scan_driver #(.BLANK_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .digit_sel (digit_sel),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .blank_lz  (blank_lz),
        .anode     (anode),
        .cathode   (cathode),
        .dp        (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] ea, input logic [6:0] ec, input logic ed);
        check_val({tag, ".anode"},   32'(anode),   32'(ea));
        check_val({tag, ".cathode"}, 32'(cathode), 32'(ec));
        check_val({tag, ".dp"},      32'(dp),      32'(ed));
    endtask

    // Change digit_sel, run 20 cycles counting all-off cycles, then check the
    // settled digit.
    task automatic step(input string tag, input logic [1:0] sel, input int exp_off,
                        input logic [3:0] ea, input logic [6:0] ec, input logic ed);
        int off;
        off = 0;
        digit_sel = sel;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (anode == 4'hF && cathode == 7'h7F && dp == 1'b1) off++;
        end
        check_val({tag, ".off_cycles"}, 32'(off), 32'(exp_off));
        check_out(tag, ea, ec, ed);
    endtask

    initial begin
        int off;
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        digit_sel = 2'd0;
        value_in  = 16'h1234;
        dp_in     = 4'h0;
        blank_lz  = 1'b0;

        tick();
        check_out("reset", 4'hF, 7'h7F, 1'b1);
        reset = 1'b0;
        tick();
        check_out("post_reset", 4'hE, 7'h40, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        check_out("hold_digit0", 4'hE, 7'h40, 1'b1);

        // First walk: frame is still zero until the 3->0 wrap.
        value_in = 16'hBEEF;
        step("w0_d1", 2'd1, 5, 4'hD, 7'h40, 1'b1);
        step("w0_d2", 2'd2, 5, 4'hB, 7'h40, 1'b1);
        step("w0_d3", 2'd3, 5, 4'h7, 7'h40, 1'b1);
        step("w1_d0", 2'd0, 5, 4'hE, 7'h0E, 1'b1);
        step("w1_d1", 2'd1, 5, 4'hD, 7'h06, 1'b1);
        step("w1_d2", 2'd2, 5, 4'hB, 7'h06, 1'b1);
        step("w1_d3", 2'd3, 5, 4'h7, 7'h03, 1'b1);
        step("w2_d0", 2'd0, 5, 4'hE, 7'h0E, 1'b1);
        step("w2_d1", 2'd1, 5, 4'hD, 7'h06, 1'b1);

        // New value mid-scan: old frame until the wrap.
        value_in = 16'h0000;
        step("mid_d2", 2'd2, 5, 4'hB, 7'h06, 1'b1);
        step("mid_d3", 2'd3, 5, 4'h7, 7'h03, 1'b1);
        step("mid_d0", 2'd0, 5, 4'hE, 7'h40, 1'b1);

        // Leading-zero suppression with decimal point on digit 1.
        value_in = 16'h0042;
        blank_lz = 1'b1;
        dp_in    = 4'b0010;
        step("lz_pre_d1", 2'd1, 5, 4'hD, 7'h40, 1'b1);
        step("lz_pre_d2", 2'd2, 5, 4'hB, 7'h40, 1'b1);
        step("lz_pre_d3", 2'd3, 5, 4'h7, 7'h40, 1'b1);
        step("lz_d0", 2'd0, 5, 4'hE, 7'h24, 1'b1);
        step("lz_d1", 2'd1, 5, 4'hD, 7'h19, 1'b0);
        step("lz_d2", 2'd2, 18, 4'hF, 7'h7F, 1'b1);
        step("lz_d3", 2'd3, 20, 4'hF, 7'h7F, 1'b1);
        step("lz_d0b", 2'd0, 7, 4'hE, 7'h24, 1'b1);
        step("lz_d1b", 2'd1, 5, 4'hD, 7'h19, 1'b0);

        // Second change two cycles into the blank window restarts the count.
        off = 0;
        digit_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (anode == 4'hF && cathode == 7'h7F && dp == 1'b1) off++;
        end
        digit_sel = 2'd1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (anode == 4'hF && cathode == 7'h7F && dp == 1'b1) off++;
        end
        check_val("restart.off_cycles", 32'(off), 32'd9);
        check_out("restart", 4'hD, 7'h19, 1'b0);

        // Load an all-F frame, then reset mid-digit.
        value_in = 16'hFFFF;
        blank_lz = 1'b0;
        dp_in    = 4'h0;
        step("ff_d2", 2'd2, 18, 4'hF, 7'h7F, 1'b1);
        step("ff_d3", 2'd3, 20, 4'hF, 7'h7F, 1'b1);
        step("ff_d0", 2'd0, 7, 4'hE, 7'h0E, 1'b1);
        step("ff_d1", 2'd1, 5, 4'hD, 7'h0E, 1'b1);
        tick();
        tick();
        reset     = 1'b1;
        digit_sel = 2'd0;
        tick();
        check_out("mid_reset", 4'hF, 7'h7F, 1'b1);
        reset = 1'b0;
        tick();
        check_out("after_reset", 4'hE, 7'h40, 1'b1);
        off = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (anode != 4'hE || cathode != 7'h40) off++;
        end
        check_val("stable.changes", 32'(off), 32'd0);
        step("ar_d1", 2'd1, 5, 4'hD, 7'h40, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
